// File: rtl/router_pkt_writer.sv
// Router packet writer: parses header/payload/parity bytes and writes FIFO words.
// Ports: clock, resetn (async low); pkt_valid, data_in in; fifo_full/empty flags
//        in; busy, write_enb (one-hot), fifo_data {byte,hdr}, err, drop out.
module router_pkt_writer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       fifo_full,
    input  logic [2:0]       fifo_empty,
    output logic             busy,
    output logic [2:0]       write_enb,
    output logic [WIDTH:0]   fifo_data,
    output logic             err,
    output logic             drop
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        PAYLOAD,
        PARITY,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       addr_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] par_q;
    logic [WIDTH-1:0] rx_q;

    logic [1:0] hdr_addr;
    logic [5:0] hdr_len;
    logic [1:0] byte_addr;
    logic       hold;
    logic       hdr_blocked;
    logic       accept;

    assign hdr_addr  = data_in[1:0];
    assign hdr_len   = data_in[7:2];
    assign byte_addr = (state_q == IDLE) ? hdr_addr : addr_q;

    // Output word still waiting on a full FIFO: one-word skid.
    assign hold = |(write_enb & fifo_full);

    // Header for a non-empty destination must wait; address 3 is never blocked.
    assign hdr_blocked = pkt_valid && (hdr_addr != 2'd3)
                         && !fifo_empty[hdr_addr];

    assign busy = hold
                  || (state_q == WAIT_EMPTY)
                  || (state_q == CHECK)
                  || ((state_q == IDLE) && hdr_blocked);

    assign accept = pkt_valid && !busy
                    && ((state_q == IDLE) || (state_q == PAYLOAD)
                        || (state_q == PARITY));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hdr_blocked) begin
                    state_d = WAIT_EMPTY;
                end else if (accept) begin
                    state_d = (hdr_len == 6'd0) ? PARITY : PAYLOAD;
                end
            end
            WAIT_EMPTY: begin
                if (fifo_empty[addr_q]) begin
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (accept && (cnt_q == 6'd1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                if (accept) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= 2'd0;
            cnt_q     <= 6'd0;
            par_q     <= '0;
            rx_q      <= '0;
            err       <= 1'b0;
            drop      <= 1'b0;
            write_enb <= 3'b000;
            fifo_data <= '0;
        end else begin
            drop <= 1'b0;

            if ((state_q == IDLE) && hdr_blocked) begin
                addr_q <= hdr_addr;
            end

            if (accept) begin
                case (state_q)
                    IDLE: begin
                        addr_q <= hdr_addr;
                        cnt_q  <= hdr_len;
                        par_q  <= data_in;
                    end
                    PAYLOAD: begin
                        cnt_q <= cnt_q - 6'd1;
                        par_q <= par_q ^ data_in;
                    end
                    PARITY: begin
                        rx_q <= data_in;
                        drop <= (addr_q == 2'd3);
                    end
                    default: begin
                    end
                endcase
            end

            // Discarded packets leave the previous verdict untouched.
            if ((state_q == CHECK) && (addr_q != 2'd3)) begin
                err <= (rx_q != par_q);
            end

            if (accept && (byte_addr != 2'd3)) begin
                write_enb <= 3'b001 << byte_addr;
                fifo_data <= {data_in, (state_q == IDLE)};
            end else if (!hold) begin
                write_enb <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_writer.sv
// Directed bench for router_pkt_writer.
// Logs completed FIFO writes and compares them with hand-computed words.
module tb_router_pkt_writer;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic       busy;
    logic [2:0] write_enb;
    logic [8:0] fifo_data;
    logic       err;
    logic       drop;

    int checks = 0;
    int errors = 0;

    logic [11:0] wq[$];
    logic [11:0] exp_q[$];

    router_pkt_writer #(.WIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .busy       (busy),
        .write_enb  (write_enb),
        .fifo_data  (fifo_data),
        .err        (err),
        .drop       (drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A write completes at the next edge when strobe is high and not full.
    always @(negedge clock) begin
        if (resetn && (write_enb != 3'b000)) begin
            chk("onehot", {31'b0, $onehot(write_enb)}, 32'd1);
            if ((write_enb & fifo_full) == 3'b000) begin
                wq.push_back({write_enb, fifo_data});
            end
        end
    end

    task automatic exp_w(input logic [2:0] we, input logic [8:0] d);
        exp_q.push_back({we, d});
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_count"}, wq.size(), exp_q.size());
        n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), {20'b0, wq[i]},
                {20'b0, exp_q[i]});
        end
        wq.delete();
        exp_q.delete();
    endtask

    // Present a byte and hold it until the DUT accepts it.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        pkt_valid = 1'b1;
        data_in   = b;
        @(negedge clock);
        while (busy && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_we", {29'b0, write_enb}, 32'd0);
        chk("rst_data", {23'b0, fifo_data}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_drop", {31'b0, drop}, 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Good packet to FIFO1, bytes back to back.
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        pkt_valid = 1'b0;
        @(negedge clock);
        chk("good_chk_busy", {31'b0, busy}, 32'd1);
        chk("good_last_we", {29'b0, write_enb}, 32'h2);
        chk("good_last_data", {23'b0, fifo_data}, 32'h01A);
        @(negedge clock);
        chk("good_we_off", {29'b0, write_enb}, 32'd0);
        chk("good_err", {31'b0, err}, 32'd0);
        exp_w(3'b010, 9'h01B); exp_w(3'b010, 9'h022);
        exp_w(3'b010, 9'h044); exp_w(3'b010, 9'h066);
        exp_w(3'b010, 9'h01A);
        check_writes("good");
        @(posedge clock);
        #1;

        // Corrupted parity byte.
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0C);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("bad_err", {31'b0, err}, 32'd1);
        exp_w(3'b010, 9'h01B); exp_w(3'b010, 9'h022);
        exp_w(3'b010, 9'h044); exp_w(3'b010, 9'h066);
        exp_w(3'b010, 9'h018);
        check_writes("bad");
        @(posedge clock);
        #1;

        // Address 3 packet is discarded; err keeps its value.
        send(8'h0B); send(8'h55); send(8'h66); send(8'h38);
        pkt_valid = 1'b0;
        @(negedge clock);
        chk("drop_pulse", {31'b0, drop}, 32'd1);
        chk("drop_chk_busy", {31'b0, busy}, 32'd1);
        @(negedge clock);
        chk("drop_clear", {31'b0, drop}, 32'd0);
        chk("drop_err_kept", {31'b0, err}, 32'd1);
        check_writes("drop");
        @(posedge clock);
        #1;

        // Zero-length good packet clears err.
        send(8'h01); send(8'h01);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("clr_err", {31'b0, err}, 32'd0);
        exp_w(3'b010, 9'h003); exp_w(3'b010, 9'h002);
        check_writes("clr");
        @(posedge clock);
        #1;

        // Destination 0 not empty: header stalls, then goes through.
        fifo_empty = 3'b110;
        pkt_valid  = 1'b1;
        data_in    = 8'h04;
        @(negedge clock);
        chk("wait_busy0", {31'b0, busy}, 32'd1);
        repeat (3) @(negedge clock);
        chk("wait_busy3", {31'b0, busy}, 32'd1);
        chk("wait_we", {29'b0, write_enb}, 32'd0);
        chk("wait_nowrites", wq.size(), 32'd0);
        @(posedge clock);
        #1;
        fifo_empty = 3'b111;
        send(8'h04);
        pkt_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        send(8'hAA); send(8'hAE);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("wait_err", {31'b0, err}, 32'd0);
        exp_w(3'b001, 9'h009); exp_w(3'b001, 9'h154);
        exp_w(3'b001, 9'h15C);
        check_writes("wait");
        @(posedge clock);
        #1;

        // FIFO2 full for four cycles mid-payload.
        send(8'h0E); send(8'h01);
        fifo_full = 3'b100;
        data_in   = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("full_busy%0d", i), {31'b0, busy}, 32'd1);
            chk($sformatf("full_we%0d", i), {29'b0, write_enb}, 32'h4);
            chk($sformatf("full_data%0d", i), {23'b0, fifo_data}, 32'h002);
        end
        @(posedge clock);
        #1;
        fifo_full = 3'b000;
        send(8'h02); send(8'h03); send(8'h0E);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("full_err", {31'b0, err}, 32'd0);
        exp_w(3'b100, 9'h01D); exp_w(3'b100, 9'h002);
        exp_w(3'b100, 9'h004); exp_w(3'b100, 9'h006);
        exp_w(3'b100, 9'h01C);
        check_writes("full");
        @(posedge clock);
        #1;

        // Reset mid-payload, then a fresh zero-length packet.
        send(8'h0D); send(8'h11);
        pkt_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_we", {29'b0, write_enb}, 32'd0);
        chk("mrst_data", {23'b0, fifo_data}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        wq.delete();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        send(8'h01); send(8'h01);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("mrst_err", {31'b0, err}, 32'd0);
        exp_w(3'b010, 9'h003); exp_w(3'b010, 9'h002);
        check_writes("mrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
